// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the data-plane matcher (port 0, fixed priority)
// and the control-plane loader (port 1), with a starvation bound and a hung-memory watchdog.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_ce_i,
    input  logic             m0_we_i,
    input  logic [`ADDR_BUS] m0_addr_i,
    input  logic [3:0]       m0_width_i,
    input  logic [`DATA_BUS] m0_data_i,
    output logic [`DATA_BUS] m0_data_o,
    output logic             m0_ready_o,
    input  logic             m1_ce_i,
    input  logic             m1_we_i,
    input  logic [`ADDR_BUS] m1_addr_i,
    input  logic [3:0]       m1_width_i,
    input  logic [`DATA_BUS] m1_data_i,
    output logic [`DATA_BUS] m1_data_o,
    output logic             m1_ready_o,
    output logic             mem_ce_o,
    output logic             mem_we_o,
    output logic [`ADDR_BUS] mem_addr_o,
    output logic [3:0]       mem_width_o,
    output logic [`DATA_BUS] mem_data_o,
    input  logic [`DATA_BUS] mem_data_i,
    input  logic             mem_ready_i,
    output logic [1:0]       grant_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam int              WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
    localparam bit              WD_EN      = (TIMEOUT != 0);

    state_t          state, state_next;
    logic [3:0]      starve_cnt, starve_next;
    logic [WD_W-1:0] wd_cnt, wd_next;
    logic            load0, load1, finish, abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wd_cnt     <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            wd_cnt     <= wd_next;
        end
    end

    // Operands are captured once at grant entry so the memory sees them stable for the whole grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ce_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_width_o <= '0;
            mem_data_o  <= '0;
        end else if (load0) begin
            mem_ce_o    <= 1'b1;
            mem_we_o    <= m0_we_i;
            mem_addr_o  <= m0_addr_i;
            mem_width_o <= m0_width_i;
            mem_data_o  <= m0_data_i;
        end else if (load1) begin
            mem_ce_o    <= 1'b1;
            mem_we_o    <= m1_we_i;
            mem_addr_o  <= m1_addr_i;
            mem_width_o <= m1_width_i;
            mem_data_o  <= m1_data_i;
        end else if (finish) begin
            mem_ce_o    <= 1'b0;
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        wd_next     = wd_cnt;
        load0       = 1'b0;
        load1       = 1'b0;
        abort       = 1'b0;
        finish      = 1'b0;
        grant_o     = 2'b00;
        m0_ready_o  = 1'b0;
        m0_data_o   = '0;
        m1_ready_o  = 1'b0;
        m1_data_o   = '0;
        timeout_o   = 1'b0;
        case (state)
            IDLE: begin
                wd_next = '0;
                if (m0_ce_i && m1_ce_i) begin
                    if (starve_cnt < STARVE_MAX) begin
                        load0       = 1'b1;
                        starve_next = starve_cnt + 4'd1;
                    end else begin
                        load1       = 1'b1;
                        starve_next = '0;
                    end
                end else if (m0_ce_i) begin
                    load0       = 1'b1;
                    starve_next = '0;
                end else if (m1_ce_i) begin
                    load1       = 1'b1;
                    starve_next = '0;
                end else begin
                    starve_next = '0;
                end
                if (load0) begin
                    state_next = GRANT0;
                end else if (load1) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // A real completion in the last watchdog cycle wins over the abort.
                abort     = WD_EN && !mem_ready_i && (wd_cnt == WD_LAST);
                finish    = mem_ready_i || abort;
                timeout_o = abort;
                if (finish) begin
                    state_next = IDLE;
                    wd_next    = '0;
                end else if (WD_EN) begin
                    wd_next = wd_cnt + WD_W'(1);
                end
                if (state == GRANT0) begin
                    grant_o    = 2'b01;
                    m0_ready_o = finish;
                    m0_data_o  = abort ? '0 : mem_data_i;
                end else begin
                    grant_o    = 2'b10;
                    m1_ready_o = finish;
                    m1_data_o  = abort ? '0 : mem_data_i;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
